// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared state enum and segment pattern constants for seg_scan_ctrl
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

    // Segment order is {a,b,c,d,e,f,g}, active-high
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1110011, SEG_DASH,   SEG_DASH,
        SEG_DASH,   SEG_DASH,   SEG_DASH,   SEG_DASH
    };

endpackage

// File: rtl/seg_decoder.sv
// rtl/seg_decoder.sv - combinational BCD to 7-segment decode, non-BCD codes show a dash
module seg_decoder
    import seg_scan_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[bcd_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scanner with frame-synchronous display update
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NDIG      = 4,
    parameter int PRESCALE  = 1000,
    parameter int BLANK_CYC = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [4*NDIG-1:0] ld_data,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   dig_en,
    output logic              frame_sync
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = $clog2(NDIG);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NDIG - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*NDIG-1:0]   pend_q, pend_d;
    logic                pend_full_q, pend_full_d;
    logic [4*NDIG-1:0]   disp_q, disp_d;
    logic [6:0]          seg_q, seg_d;
    logic [NDIG-1:0]     dig_en_q, dig_en_d;

    logic                accept;
    logic                frame_end;
    logic                commit;
    logic [3:0]          cur_digit;
    logic [6:0]          dec_seg;
    logic                lz_blank;

    assign ld_ready   = ~pend_full_q;
    assign accept     = ld_valid && !pend_full_q;
    assign frame_end  = (state_q == ST_SHOW) && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    assign frame_sync = frame_end;
    // Display only changes between frames, or immediately when nothing is shown yet
    assign commit     = pend_full_q && ((state_q == ST_IDLE) || frame_end);

    assign seg    = seg_q;
    assign dig_en = dig_en_q;

    always_comb begin
        cur_digit = 4'd0;
        for (int j = 0; j < NDIG; j++) begin
            if (idx_q == IDX_W'(j)) begin
                cur_digit = disp_q[4*j +: 4];
            end
        end
    end

`ifdef SEG_SCAN_LZB_EN
    // A digit is a leading zero when it and every digit above it are zero
    always_comb begin
        lz_blank = (idx_q != '0);
        for (int j = 0; j < NDIG; j++) begin
            if ((IDX_W'(j) >= idx_q) && (disp_q[4*j +: 4] != 4'd0)) begin
                lz_blank = 1'b0;
            end
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    seg_decoder u_dec (
        .bcd_i (cur_digit),
        .seg_o (dec_seg)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (commit) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_BLANK: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    state_d = ST_BLANK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // accept and commit are mutually exclusive: commit needs pend_full, accept needs it clear
    always_comb begin
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        disp_d      = disp_q;
        if (commit) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_d      = ld_data;
            pend_full_d = 1'b1;
        end
    end

    always_comb begin
        seg_d    = SEG_BLANK;
        dig_en_d = '0;
        if (state_q == ST_SHOW) begin
            seg_d = lz_blank ? SEG_BLANK : dec_seg;
            for (int j = 0; j < NDIG; j++) begin
                dig_en_d[j] = (idx_q == IDX_W'(j));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            disp_q      <= '0;
            seg_q       <= SEG_BLANK;
            dig_en_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            disp_q      <= disp_d;
            seg_q       <= seg_d;
            dig_en_q    <= dig_en_d;
        end
    end

endmodule
